enemy_control: RTL and testbench
================================

ENEMY_CONTROL -- requirements
Module: enemy_control

Interface
REQ-001 SHALL have parameter FRAME_CYCLES, default 833334, clock cycles per frame tick (60 Hz at 50 MHz); legal range 8 to 2^20.
REQ-002 SHALL have parameter MOVE_DIV, default 2, frame ticks per movement step (1 to 15).
REQ-003 SHALL have parameter DRAW_TIMEOUT, default 1024, draw watchdog limit in cycles (used only with the macro).
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high; one clock, and reset is asynchronous and active-high.
REQ-006 enable  input  1  game running; 0 holds the FSM in IDLE and freezes the frame counter.
REQ-007 restart  input  1  one-cycle request to re-run INIT (enemy respawn).
REQ-008 draw_done  input  1  from enemy: sprite draw complete, registered, held high until the enemy leaves draw.
REQ-009 init, idle, gen_move, apply_move, draw  output  1 each  one-hot state strobes to the enemy, registered.
REQ-010 frame_tick  output  1  one-cycle pulse each FRAME_CYCLES cycles.
REQ-011 overrun  output  1  sticky: a frame tick arrived while not in IDLE.
REQ-012 draw_timeout  output  1  sticky watchdog flag; constant 0 without the macro.

Function
REQ-013 States SHALL be INIT, IDLE, GEN_MOVE, SETTLE, APPLY_MOVE, DRAW; exactly one of init/idle/gen_move/apply_move/draw is high per cycle; SETTLE asserts none.
REQ-014 INIT SHALL last exactly one cycle, clear the move divider, then go to IDLE.
REQ-015 Frame counter SHALL count 0..FRAME_CYCLES-1 while enable=1, wrap to 0, and pulse frame_tick in the cycle its value is FRAME_CYCLES-1.
REQ-016 In IDLE with frame_tick=1: if move divider = MOVE_DIV-1, clear it and go to GEN_MOVE; otherwise increment it and go to DRAW.
REQ-017 GEN_MOVE -> SETTLE -> APPLY_MOVE -> DRAW, one cycle each; SETTLE gives the collision detector one cycle to register the new direction.
REQ-018 DRAW SHALL hold until draw_done=1 is sampled, then go to IDLE; draw_done is ignored in every other state.
REQ-019 At least one IDLE cycle SHALL separate consecutive DRAW states, so the enemy clears a stale draw_done.
REQ-020 frame_tick outside IDLE SHALL set overrun and be dropped; the divider does not advance.
REQ-021 restart SHALL have priority over all transitions and go to INIT next cycle from any state, including mid-DRAW.
REQ-022 enable=0 SHALL force IDLE next cycle from any state and zero the frame counter; the divider is kept.
REQ-023 restart and enable=0 in the same cycle: INIT for one cycle, then IDLE.

Reset
REQ-024 Reset SHALL asynchronously set state INIT (init=1, other strobes 0), frame counter 0, divider 0, frame_tick 0, overrun 0, draw_timeout 0, watchdog 0.
REQ-025 After reset release, INIT SHALL last one cycle, then IDLE.
REQ-026 Sticky flags SHALL clear only on reset.

Configuration
REQ-027 Macro ENEMY_CTRL_WATCHDOG_EN: when defined, a counter runs in DRAW; at DRAW_TIMEOUT cycles without draw_done the FSM goes to IDLE and sets draw_timeout.
REQ-028 Without ENEMY_CTRL_WATCHDOG_EN, no watchdog logic is built; DRAW waits indefinitely and draw_timeout ties to 0.

Verification (FRAME_CYCLES=16, MOVE_DIV=2, DRAW_TIMEOUT=8)
REQ-029 Reset, enable=1, draw_done after 4 DRAW cycles -> init one cycle; frame_tick every 16 cycles; ticks alternate IDLE->DRAW and IDLE->GEN_MOVE->SETTLE->APPLY_MOVE->DRAW.
REQ-030 draw_done held low for 20 cycles, then high -> overrun=1 after the next tick; the FSM stays in DRAW until draw_done, then IDLE.
REQ-031 restart pulsed during APPLY_MOVE -> INIT next cycle, then IDLE; the divider restarts so the second tick gives GEN_MOVE.
REQ-032 enable dropped during DRAW for 10 cycles -> IDLE next cycle, frame_tick absent; after re-enable, first tick 16 cycles later.
REQ-033 With ENEMY_CTRL_WATCHDOG_EN, draw_done never asserted -> IDLE after 8 DRAW cycles, draw_timeout=1; without the macro -> DRAW held, draw_timeout=0.
REQ-034 Reset asserted mid-DRAW, asynchronous to clock -> outputs immediately go to reset values (init=1) before the next clock edge.

Source files
------------

// File: rtl/enemy_control.sv
// rtl/enemy_control.sv - frame-paced enemy move/draw sequencer; optional draw watchdog under `ENEMY_CTRL_WATCHDOG_EN
`timescale 1ns/1ps
module enemy_control #(
    parameter int FRAME_CYCLES = 833334,
    parameter int MOVE_DIV     = 2,
    parameter int DRAW_TIMEOUT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    input  logic draw_done,
    output logic init,
    output logic idle,
    output logic gen_move,
    output logic apply_move,
    output logic draw,
    output logic frame_tick,
    output logic overrun,
    output logic draw_timeout
);

    localparam int               CNT_W    = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [3:0]       DIV_LAST = 4'(MOVE_DIV - 1);

    if (FRAME_CYCLES < 8 || FRAME_CYCLES > (1 << 20) || MOVE_DIV < 1 || MOVE_DIV > 15 ||
        DRAW_TIMEOUT < 1) begin : g_param_check
        $error("enemy_control: parameter out of range");
    end

    // One-hot encoding so every strobe is a flop output; SETTLE drives none of them.
    typedef enum logic [5:0] {
        S_INIT   = 6'b000001,
        S_IDLE   = 6'b000010,
        S_GEN    = 6'b000100,
        S_SETTLE = 6'b001000,
        S_APPLY  = 6'b010000,
        S_DRAW   = 6'b100000
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] frame_cnt;
    logic [3:0]       move_div;
    logic [3:0]       move_div_next;
    logic             wd_expired;

    assign init       = state[0];
    assign idle       = state[1];
    assign gen_move   = state[2];
    assign apply_move = state[4];
    assign draw       = state[5];

    assign frame_tick = enable && (frame_cnt == CNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (!enable || frame_tick) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_next    = state;
        move_div_next = move_div;
        if (restart) begin
            state_next = S_INIT;
        end else if (!enable) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_INIT:   state_next = S_IDLE;
                S_IDLE: begin
                    if (frame_tick) begin
                        if (move_div == DIV_LAST) begin
                            move_div_next = '0;
                            state_next    = S_GEN;
                        end else begin
                            move_div_next = move_div + 4'd1;
                            state_next    = S_DRAW;
                        end
                    end
                end
                S_GEN:    state_next = S_SETTLE;
                S_SETTLE: state_next = S_APPLY;
                S_APPLY:  state_next = S_DRAW;
                S_DRAW: begin
                    if (draw_done || wd_expired) begin
                        state_next = S_IDLE;
                    end
                end
                default:  state_next = S_INIT;
            endcase
        end
        // Respawn always restarts the movement cadence, whatever the exit path.
        if (state == S_INIT) begin
            move_div_next = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_INIT;
            move_div <= '0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_next;
            move_div <= move_div_next;
            overrun  <= overrun | (frame_tick && (state != S_IDLE));
        end
    end

`ifdef ENEMY_CTRL_WATCHDOG_EN
    localparam int            WD_W    = $clog2(DRAW_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(DRAW_TIMEOUT - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            draw_timeout_q;

    assign wd_expired   = (state == S_DRAW) && !draw_done && (wd_cnt == WD_LAST);
    assign draw_timeout = draw_timeout_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_cnt         <= '0;
            draw_timeout_q <= 1'b0;
        end else begin
            if (state != S_DRAW || wd_expired) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            draw_timeout_q <= draw_timeout_q | (wd_expired && !restart && enable);
        end
    end
`else
    assign wd_expired   = 1'b0;
    assign draw_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_enemy_control.sv
// tb/tb_enemy_control.sv - directed scoreboard bench for enemy_control (FRAME_CYCLES=16, MOVE_DIV=2, DRAW_TIMEOUT=8)
`timescale 1ns/1ps
module tb_enemy_control;

    localparam logic [4:0] V_INIT   = 5'b10000;
    localparam logic [4:0] V_IDLE   = 5'b01000;
    localparam logic [4:0] V_GEN    = 5'b00100;
    localparam logic [4:0] V_SETTLE = 5'b00000;
    localparam logic [4:0] V_APPLY  = 5'b00010;
    localparam logic [4:0] V_DRAW   = 5'b00001;

    localparam int K_NONE    = 0;
    localparam int K_RESTART = 1;
    localparam int K_ENABLE  = 2;
    localparam int K_RESET   = 3;
    localparam int K_WDOG    = 4;

    logic clock = 1'b0;
    logic reset, enable, restart, draw_done;
    logic init, idle, gen_move, apply_move, draw, frame_tick, overrun, draw_timeout;
    logic [4:0] strobes;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_tick   = 0;
    logic [4:0] exp_q[$];

    assign strobes = {init, idle, gen_move, apply_move, draw};

    always #5 clock = ~clock;

    enemy_control #(
        .FRAME_CYCLES(16),
        .MOVE_DIV    (2),
        .DRAW_TIMEOUT(8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .restart     (restart),
        .draw_done   (draw_done),
        .init        (init),
        .idle        (idle),
        .gen_move    (gen_move),
        .apply_move  (apply_move),
        .draw        (draw),
        .frame_tick  (frame_tick),
        .overrun     (overrun),
        .draw_timeout(draw_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic expect_next(input string tag);
        logic [4:0] e;
        e = exp_q.pop_front();
        check(tag, {27'd0, strobes}, {27'd0, e});
    endtask

    task automatic wait_tick(input string tag, input int gap);
        int k;
        k = 0;
        while (frame_tick !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        check({tag, "_tick_gap"}, cyc - last_tick, gap);
        check({tag, "_tick_idle"}, {27'd0, strobes}, {27'd0, V_IDLE});
        last_tick = cyc;
    endtask

    task automatic do_abort(input string tag, input int kind);
        case (kind)
            K_RESTART: begin
                restart = 1'b1;
                exp_q.push_back(V_INIT);
                step();
                restart = 1'b0;
                expect_next({tag, "_restart_init"});
                exp_q.push_back(V_IDLE);
                step();
                expect_next({tag, "_restart_idle"});
            end
            K_ENABLE: begin
                enable = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    exp_q.push_back(V_IDLE);
                    step();
                    expect_next({tag, "_disabled_idle"});
                    check({tag, "_disabled_tick"}, {31'd0, frame_tick}, 32'd0);
                end
                enable    = 1'b1;
                last_tick = cyc;
            end
            K_RESET: begin
                #2;
                reset = 1'b1;
                #1;
                check({tag, "_async_strobes"}, {27'd0, strobes}, {27'd0, V_INIT});
                check({tag, "_async_overrun"}, {31'd0, overrun}, 32'd0);
                check({tag, "_async_tick"}, {31'd0, frame_tick}, 32'd0);
                check({tag, "_async_timeout"}, {31'd0, draw_timeout}, 32'd0);
                step();
                step();
                reset     = 1'b0;
                last_tick = cyc;
                check({tag, "_release_init"}, {27'd0, strobes}, {27'd0, V_INIT});
                step();
                check({tag, "_release_idle"}, {27'd0, strobes}, {27'd0, V_IDLE});
            end
            K_WDOG: begin
                exp_q.push_back(V_IDLE);
                step();
                expect_next({tag, "_wdog_idle"});
                check({tag, "_wdog_flag"}, {31'd0, draw_timeout}, 32'd1);
            end
            default: ;
        endcase
    endtask

    // One frame: wait for the tick in IDLE, then follow the expected strobe sequence.
    task automatic run_frame(input string tag, input bit mv, input int dlen, input int gap,
                             input int abort_at, input int abort_kind);
        int n;
        bit aborted;
        aborted = 1'b0;
        wait_tick(tag, gap);
        if (mv) begin
            exp_q.push_back(V_GEN);
            exp_q.push_back(V_SETTLE);
            exp_q.push_back(V_APPLY);
        end
        for (int i = 0; i < dlen; i++) exp_q.push_back(V_DRAW);
        n = exp_q.size();
        for (int i = 0; i < n && !aborted; i++) begin
            step();
            expect_next({tag, "_seq"});
            if (i + 1 == abort_at) begin
                aborted = 1'b1;
                exp_q.delete();
                do_abort(tag, abort_kind);
            end
        end
        if (!aborted) begin
            draw_done = 1'b1;
            exp_q.push_back(V_IDLE);
            step();
            draw_done = 1'b0;
            expect_next({tag, "_done_idle"});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        restart   = 1'b0;
        draw_done = 1'b0;
        step();
        step();
        check("reset_strobes", {27'd0, strobes}, {27'd0, V_INIT});
        check("reset_tick", {31'd0, frame_tick}, 32'd0);
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        check("reset_timeout", {31'd0, draw_timeout}, 32'd0);

        reset     = 1'b0;
        enable    = 1'b1;
        cyc       = 0;
        last_tick = 0;
        check("post_reset_init", {27'd0, strobes}, {27'd0, V_INIT});
        step();
        check("post_reset_idle", {27'd0, strobes}, {27'd0, V_IDLE});

        run_frame("f1_draw", 1'b0, 4, 15, 0, K_NONE);
        run_frame("f2_move", 1'b1, 4, 16, 0, K_NONE);
        run_frame("f3_draw", 1'b0, 4, 16, 0, K_NONE);
        run_frame("f4_move", 1'b1, 4, 16, 0, K_NONE);
        check("no_overrun_yet", {31'd0, overrun}, 32'd0);

        // The tick arriving mid-DRAW is dropped, so the divider still selects a move next.
        run_frame("f5_long_draw", 1'b0, 20, 16, 0, K_NONE);
        check("overrun_set", {31'd0, overrun}, 32'd1);
        run_frame("f6_move", 1'b1, 4, 32, 0, K_NONE);
        check("overrun_sticky", {31'd0, overrun}, 32'd1);

        run_frame("f7_draw", 1'b0, 4, 16, 0, K_NONE);
        run_frame("f8_restart_apply", 1'b1, 4, 16, 3, K_RESTART);
        run_frame("f9_restart_draw", 1'b0, 4, 16, 2, K_RESTART);
        run_frame("f10_draw", 1'b0, 4, 16, 0, K_NONE);
        run_frame("f11_move", 1'b1, 4, 16, 0, K_NONE);

        run_frame("f12_disable", 1'b0, 4, 16, 2, K_ENABLE);
        run_frame("f13_move", 1'b1, 4, 15, 0, K_NONE);

`ifdef ENEMY_CTRL_WATCHDOG_EN
        run_frame("f14_wdog", 1'b0, 8, 16, 8, K_WDOG);
`else
        run_frame("f14_no_wdog", 1'b0, 12, 16, 0, K_NONE);
        check("no_wdog_flag", {31'd0, draw_timeout}, 32'd0);
`endif

        run_frame("f15_async_reset", 1'b1, 4, 16, 5, K_RESET);
        check("overrun_cleared", {31'd0, overrun}, 32'd0);

        restart = 1'b1;
        enable  = 1'b0;
        exp_q.push_back(V_INIT);
        step();
        restart = 1'b0;
        expect_next("restart_disable_init");
        exp_q.push_back(V_IDLE);
        step();
        expect_next("restart_disable_idle");
        enable    = 1'b1;
        last_tick = cyc;

        run_frame("f16_draw", 1'b0, 4, 15, 0, K_NONE);
        run_frame("f17_move", 1'b1, 4, 16, 0, K_NONE);
        check("final_overrun", {31'd0, overrun}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
